// File: rtl/dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dm_responder
// Purpose  : Responder end of the CPU data-memory interface. Decodes the CPU
//            byte address against the data segment base, serves word reads and
//            writes from an internal RAM with a configurable read latency, and
//            reports out-of-range, misaligned or malformed requests.
// Ports    : clk        - single clock, all state on rising edge
//            reset      - asynchronous, active-low reset
//            DM_CS      - request strobe
//            DM_R/DM_W  - read / write qualifiers (exactly one must be set)
//            DM_addr    - byte address from the CPU
//            DM_wdata   - write data
//            rdata      - read data, valid while DM_ready=1 and DM_err=0
//            DM_ready   - one-cycle completion pulse
//            DM_err     - one-cycle error pulse, coincident with DM_ready
//            err_addr   - address of the most recent erroneous request
//            err_count  - erroneous request count, saturating at 255
// Revision : 1.0 - initial release
// ============================================================================
module dm_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          ADDR_W    = 11,
  parameter int          RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DM_CS,
  input  logic        DM_R,
  input  logic        DM_W,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] rdata,
  output logic        DM_ready,
  output logic        DM_err,
  output logic [31:0] err_addr,
  output logic [7:0]  err_count
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic [31:0] err_addr_q;
  logic [7:0]  err_count_q;

  logic [31:0] mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Address decode. The subtraction wraps, so addresses below the base land
  // far above the segment size and fall out of range naturally.
  // --------------------------------------------------------------------------
  logic [31:0]       req_off;
  logic [ADDR_W-1:0] req_idx;
  logic              req_in_range;
  logic              req_aligned;
  logic              req_one_op;
  logic              req_legal;
  logic              acc;
  logic              acc_wr;
  logic              acc_rd;
  logic              acc_bad;
  logic [31:0]       rd_word;

  assign req_off      = DM_addr - BASE_ADDR;
  assign req_idx      = req_off[ADDR_W+1:2];
  assign req_in_range = (req_off[31:ADDR_W+2] == '0);
  assign req_aligned  = (req_off[1:0] == 2'b00);
  assign req_one_op   = DM_R ^ DM_W;
  assign req_legal    = req_in_range & req_aligned & req_one_op;

  // Requests are only looked at in IDLE; anything presented while a request
  // is in flight is dropped and the CPU has to present it again.
  assign acc     = (state_q == ST_IDLE) & DM_CS;
  assign acc_wr  = acc & req_legal & DM_W;
  assign acc_rd  = acc & req_legal & DM_R;
  assign acc_bad = acc & ~req_legal;

  // --------------------------------------------------------------------------
  // Word RAM. Deliberately not reset so contents survive a reset pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem_q[req_idx] <= DM_wdata;
    end
  end

  assign rd_word = mem_q[req_idx];

  // --------------------------------------------------------------------------
  // Read pipeline. The RAM is sampled on the accepting edge; the word then
  // travels RD_LAT-1 stages, the last of which is the rdata register itself.
  // fin_vld marks the cycle in which the read word is loaded into rdata.
  // --------------------------------------------------------------------------
  logic        fin_vld;
  logic [31:0] fin_data;

  if (RD_LAT == 1) begin : g_lat1
    assign fin_vld  = acc_rd;
    assign fin_data = rd_word;
  end else begin : g_pipe
    logic [RD_LAT-2:0] vld_q;
    logic [31:0]       data_q [RD_LAT-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= acc_rd;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    // Data stages carry no reset; only the valid bits decide whether they
    // are ever consumed.
    always_ff @(posedge clk) begin
      if (acc_rd) begin
        data_q[0] <= rd_word;
      end
      for (int i = 1; i < RD_LAT - 1; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign fin_vld  = vld_q[RD_LAT-2];
    assign fin_data = data_q[RD_LAT-2];
  end

  // --------------------------------------------------------------------------
  // Control FSM: IDLE -> (WAIT ->) RESP -> IDLE
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (DM_CS) begin
          if (acc_rd && (RD_LAT > 1)) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        // The last pipeline stage fires on the edge that enters RESP.
        if (fin_vld) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Response flags are registered alongside the state so DM_ready is high for
  // exactly the cycle spent in RESP.
  assign ready_d = (state_d == ST_RESP);
  assign err_d   = acc_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;

      // rdata holds the last read word until the next read or error response.
      if (acc_bad) begin
        rdata_q <= '0;
      end else if (fin_vld) begin
        rdata_q <= fin_data;
      end

      if (acc_bad) begin
        err_addr_q <= DM_addr;
        if (err_count_q != 8'hFF) begin
          err_count_q <= err_count_q + 8'd1;
        end
      end
    end
  end

  assign rdata     = rdata_q;
  assign DM_ready  = ready_q;
  assign DM_err    = err_q;
  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Self-checking bench for dm_responder. A driver issues directed
//            requests and queues the expected response; a monitor pops and
//            compares whenever DM_ready is seen. Two extra instances with
//            read latencies 1 and 4 check the latency parameterisation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cs, rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, err;
  logic [31:0] err_addr;
  logic [7:0]  err_count;

  dm_responder #(.BASE_ADDR(BASE), .ADDR_W(11), .RD_LAT(2)) u_dut (
    .clk(clk), .reset(rst_n), .DM_CS(cs), .DM_R(rd), .DM_W(wr),
    .DM_addr(addr), .DM_wdata(wdata), .rdata(rdata), .DM_ready(ready),
    .DM_err(err), .err_addr(err_addr), .err_count(err_count)
  );

  // Latency variants share one set of inputs.
  logic        lcs, lr, lw;
  logic [31:0] laddr, lwd;
  logic [31:0] l1_rdata, l4_rdata, l1_ea, l4_ea;
  logic        l1_ready, l4_ready, l1_err, l4_err;
  logic [7:0]  l1_ec, l4_ec;

  dm_responder #(.BASE_ADDR(BASE), .ADDR_W(11), .RD_LAT(1)) u_l1 (
    .clk(clk), .reset(rst_n), .DM_CS(lcs), .DM_R(lr), .DM_W(lw),
    .DM_addr(laddr), .DM_wdata(lwd), .rdata(l1_rdata), .DM_ready(l1_ready),
    .DM_err(l1_err), .err_addr(l1_ea), .err_count(l1_ec)
  );

  dm_responder #(.BASE_ADDR(BASE), .ADDR_W(11), .RD_LAT(4)) u_l4 (
    .clk(clk), .reset(rst_n), .DM_CS(lcs), .DM_R(lr), .DM_W(lw),
    .DM_addr(laddr), .DM_wdata(lwd), .rdata(l4_rdata), .DM_ready(l4_ready),
    .DM_err(l4_err), .err_addr(l4_ea), .err_count(l4_ec)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    time         t;      // negedge at which DM_ready must be observed
    bit          err;
    bit          chk_rd; // compare rdata (reads and errors only)
    logic [31:0] rd;
    logic [31:0] ea;
    logic [7:0]  ec;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int          exp_ec = 0;
  logic [31:0] exp_ea = '0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ready === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got DM_ready=1 at %0t expected no response", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_time", 32'($time), 32'(mon_e.t));
        chk("resp_err", {31'd0, err}, {31'd0, mon_e.err});
        if (mon_e.chk_rd) chk("resp_rdata", rdata, mon_e.rd);
        chk("resp_err_addr", err_addr, mon_e.ea);
        chk("resp_err_count", {24'd0, err_count}, {24'd0, mon_e.ec});
      end
    end
  end

  task automatic wait_empty();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: got no DM_ready, expected %0d pending responses", sbq.size());
      sbq.delete();
    end
  endtask

  // Issue one request; lat is the expected accept-to-ready distance in cycles.
  // hold keeps DM_CS asserted (with another address) through WAIT and RESP.
  task automatic req(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input bit e_err,
                     input logic [31:0] e_rd, input int lat, input bit hold);
    exp_t x;
    @(negedge clk);
    cs = 1'b1; rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk);
    x.t = $time + time'((lat - 1) * 10 + 5);
    if (e_err) begin
      exp_ea = a;
      if (exp_ec < 255) exp_ec++;
    end
    x.err    = e_err;
    x.chk_rd = e_err || (r && !w);
    x.rd     = e_err ? 32'd0 : e_rd;
    x.ea     = exp_ea;
    x.ec     = 8'(exp_ec);
    sbq.push_back(x);
    if (hold) begin
      @(negedge clk);
      addr = BASE + 32'h4; rd = 1'b1; wr = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      @(negedge clk);
    end
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    wait_empty();
  endtask

  // --------------------------------------------------------------------------
  // Latency-variant monitors
  // --------------------------------------------------------------------------
  int          l1_n = 0, l4_n = 0;
  time         l1_t = 0, l4_t = 0;
  logic [31:0] l1_d = '0, l4_d = '0;
  logic        l1_e = 1'b0, l4_e = 1'b0;

  always @(negedge clk) begin
    if (l1_ready === 1'b1) begin
      l1_n++; l1_t = $time; l1_d = l1_rdata; l1_e = l1_e | l1_err;
    end
    if (l4_ready === 1'b1) begin
      l4_n++; l4_t = $time; l4_d = l4_rdata; l4_e = l4_e | l4_err;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected $finish before 400000 ns");
    $fatal(1);
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin
    time t0;
    rst_n = 1'b0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    lcs = 1'b0; lr = 1'b0; lw = 1'b0; laddr = '0; lwd = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err_addr", err_addr, 32'd0);
    chk("reset_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read back, read latency 2
    req(1'b0, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, 32'h0, 1, 1'b0);
    req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0);

    // Out of range above the segment and below the base (wrap)
    req(1'b1, 1'b0, 32'h1001_2000, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    req(1'b1, 1'b0, 32'h1000_FFFC, 32'h0, 1'b1, 32'h0, 1, 1'b0);

    // Misaligned, both qualifiers, no qualifier
    req(1'b0, 1'b1, 32'h1001_0000, 32'h1111_1111, 1'b0, 32'h0, 1, 1'b0);
    req(1'b0, 1'b1, 32'h1001_0002, 32'h2222_2222, 1'b1, 32'h0, 1, 1'b0);
    req(1'b1, 1'b1, 32'h1001_0000, 32'h3333_3333, 1'b1, 32'h0, 1, 1'b0);
    req(1'b0, 1'b0, 32'h1001_0004, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    req(1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h1111_1111, 2, 1'b0);

    // Last word of the segment
    req(1'b0, 1'b1, 32'h1001_1FFC, 32'hA5A5_5A5A, 1'b0, 32'h0, 1, 1'b0);
    req(1'b1, 1'b0, 32'h1001_1FFC, 32'h0, 1'b0, 32'hA5A5_5A5A, 2, 1'b0);

    // Second request held during WAIT/RESP is ignored
    req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);

    // Reset pulsed while a read is in WAIT: outputs clear at once, no DM_ready
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 32'h1001_0000;
    @(posedge clk);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err_addr", err_addr, 32'd0);
    chk("midrst_err_count", {24'd0, err_count}, 32'd0);
    exp_ec = 0;
    exp_ea = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // RAM survives reset
    req(1'b1, 1'b0, 32'h1001_0008, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0);
    req(1'b1, 1'b0, 32'h1001_0000, 32'h0, 1'b0, 32'h1111_1111, 2, 1'b0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) begin
      req(1'b0, 1'b0, 32'h1001_0010, 32'h0, 1'b1, 32'h0, 1, 1'b0);
    end
    #1;
    chk("sat_err_count", {24'd0, err_count}, 32'd255);

    // Latency 1 and 4 instances: write then read
    @(negedge clk);
    lcs = 1'b1; lw = 1'b1; laddr = 32'h1001_0010; lwd = 32'hCAFE_F00D;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    lcs = 1'b0; lw = 1'b0;
    repeat (6) @(negedge clk);
    chk("l1_wr_count", 32'(l1_n), 32'd1);
    chk("l4_wr_count", 32'(l4_n), 32'd1);
    chk("l1_wr_time", 32'(l1_t), 32'(t0 + 5));
    chk("l4_wr_time", 32'(l4_t), 32'(t0 + 5));

    @(negedge clk);
    lcs = 1'b1; lr = 1'b1;
    @(posedge clk);
    t0 = $time;
    @(negedge clk);
    lcs = 1'b0; lr = 1'b0;
    repeat (8) @(negedge clk);
    chk("l1_rd_count", 32'(l1_n), 32'd2);
    chk("l4_rd_count", 32'(l4_n), 32'd2);
    chk("l1_rd_time", 32'(l1_t), 32'(t0 + 5));
    chk("l4_rd_time", 32'(l4_t), 32'(t0 + 35));
    chk("l1_rd_data", l1_d, 32'hCAFE_F00D);
    chk("l4_rd_data", l4_d, 32'hCAFE_F00D);
    chk("l1_no_err", {31'd0, l1_e}, 32'd0);
    chk("l4_no_err", {31'd0, l4_e}, 32'd0);
    chk("l1_err_count", {24'd0, l1_ec} | l1_ea, 32'd0);
    chk("l4_err_count", {24'd0, l4_ec} | l4_ea, 32'd0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
